// File: rtl/result_uart_tx.sv
// ---------------------------------------------------------------------------
// result_uart_tx
//
// Result drain for the 4x4 systolic multiplier. When the array strobes
// `done`, all sixteen C results are captured into a snapshot. They are then
// sent off-chip as a single framed 8N1 UART packet:
//
//   byte 0            : HEADER
//   bytes 1 .. 16*B   : C0..C15, each word low byte first (B = OUT_WIDTH/8)
//   byte 16*B+1       : XOR of every data byte (HEADER is not included)
//
// Bytes are sent back to back, with no idle bits between them. Every bit
// lasts exactly CLKS_PER_BIT clocks.
//
// Parameters
//   OUT_WIDTH     width of one result word; must be a multiple of 8
//   CLKS_PER_BIT  clk cycles per UART bit; minimum 2
//   HEADER        first byte of every frame
//
// Ports
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   done        in   capture strobe; only sampled while idle
//   c_flat      in   16*OUT_WIDTH; C0 in the LSBs, C15 in the MSBs
//   tx          out  UART serial line, idles high, registered
//   busy        out  high from the cycle after capture until the frame ends
//   frame_done  out  one-cycle pulse on the edge that ends the last stop bit
// ---------------------------------------------------------------------------
module result_uart_tx #(
  parameter int          OUT_WIDTH    = 16,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done,
  input  logic [16*OUT_WIDTH-1:0]   c_flat,
  output logic                      tx,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int BYTES_PER_WORD = OUT_WIDTH / 8;
  localparam int DATA_BYTES     = 16 * BYTES_PER_WORD;
  localparam int FRAME_BYTES    = DATA_BYTES + 2;
  localparam int SNAP_W         = 16 * OUT_WIDTH;
  localparam int IDX_W          = $clog2(FRAME_BYTES);
  localparam int DSEL_W         = $clog2(DATA_BYTES);
  localparam int BAUD_W         = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST      = IDX_W'(FRAME_BYTES - 1);
  // Byte index whose STOP bit precedes the checksum byte.
  localparam logic [IDX_W-1:0]  IDX_PRE_CSUM  = IDX_W'(FRAME_BYTES - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q,      state_d;
  logic [BAUD_W-1:0]   baud_q,       baud_d;
  logic [2:0]          bit_q,        bit_d;
  logic [IDX_W-1:0]    idx_q,        idx_d;
  logic [7:0]          csum_q,       csum_d;
  logic [7:0]          byte_q,       byte_d;
  logic [SNAP_W-1:0]   snap_q,       snap_d;
  logic                tx_q,         tx_d;
  logic                busy_q,       busy_d;
  logic                frame_done_q, frame_done_d;

  // -------------------------------------------------------------------------
  // Byte view of the snapshot. C0 sits in the LSBs and each word is sent
  // low byte first, so frame data byte k is simply snapshot bits [8k +: 8].
  // -------------------------------------------------------------------------
  logic [7:0] snap_byte [DATA_BYTES];

  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_snap_byte
      assign snap_byte[gi] = snap_q[8*gi +: 8];
    end
  endgenerate

  // In STOP the index still points at the byte that is ending. The next
  // frame byte is idx_q+1, which is data byte idx_q, because data bytes
  // start at frame index 1.
  logic [DSEL_W-1:0] next_dsel;
  logic [7:0]        next_data_byte;
  logic              baud_wrap;

  assign next_dsel      = DSEL_W'(idx_q);
  assign next_data_byte = snap_byte[next_dsel];
  assign baud_wrap      = (baud_q == BAUD_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    byte_d       = byte_q;
    snap_d       = snap_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (done) begin
          snap_d  = c_flat;
          idx_d   = '0;
          csum_d  = 8'h00;
          byte_d  = HEADER;
          bit_d   = 3'd0;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = byte_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = byte_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            // Last stop bit done: frame_done and busy change together.
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            tx_d         = 1'b1;
          end else begin
            // Straight into the next start bit; no idle gap.
            idx_d   = idx_q + 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
            if (idx_q == IDX_PRE_CSUM) begin
              // The accumulator already covers every data byte.
              byte_d = csum_q;
            end else begin
              byte_d = next_data_byte;
              csum_d = csum_q ^ next_data_byte;
            end
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. The snapshot has no reset; its contents only matter after a
  // capture, and a capture always reloads all of it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      idx_q        <= '0;
      csum_q       <= 8'h00;
      byte_q       <= 8'h00;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      byte_q       <= byte_d;
      snap_q       <= snap_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_result_uart_tx
//
// Three result_uart_tx instances share clk, reset and c_flat:
//   dut 0: CLKS_PER_BIT=4 (main tests), dut 1: 2, dut 2: 7 (baud sweep).
// The stimulus pushes the expected frame bytes and the expected busy length
// into per-instance queues. For each instance, a UART receiver and a
// busy/frame_done monitor pop from those queues and compare.
// ---------------------------------------------------------------------------
module tb_result_uart_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   done_w;
  logic [255:0] c_flat;
  logic [2:0]   tx_w;
  logic [2:0]   busy_w;
  logic [2:0]   fd_w;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  int         l0 [$];
  int         l1 [$];
  int         l2 [$];
  int         exp_frames  [3] = '{0, 0, 0};
  int         seen_frames [3] = '{0, 0, 0};
  logic [7:0] frame_buf [$];

  always #5 clk = ~clk;

  result_uart_tx #(.OUT_WIDTH(16), .CLKS_PER_BIT(4), .HEADER(8'hA5)) u_dut4 (
    .clk(clk), .reset(reset), .done(done_w[0]), .c_flat(c_flat),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  result_uart_tx #(.OUT_WIDTH(16), .CLKS_PER_BIT(2), .HEADER(8'hA5)) u_dut2 (
    .clk(clk), .reset(reset), .done(done_w[1]), .c_flat(c_flat),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  result_uart_tx #(.OUT_WIDTH(16), .CLKS_PER_BIT(7), .HEADER(8'hA5)) u_dut7 (
    .clk(clk), .reset(reset), .done(done_w[2]), .c_flat(c_flat),
    .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cpb_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 2 : 7);
  endfunction

  task automatic exp_pop(input int d, output logic [7:0] b, output bit ok);
    ok = 1'b1;
    b  = 8'h00;
    case (d)
      0: if (q0.size() > 0) b = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) b = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) b = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic len_pop(input int d, output int len, output bit ok);
    ok  = 1'b1;
    len = 0;
    case (d)
      0: if (l0.size() > 0) len = l0.pop_front(); else ok = 1'b0;
      1: if (l1.size() > 0) len = l1.pop_front(); else ok = 1'b0;
      default: if (l2.size() > 0) len = l2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Queue the frame held in frame_buf as the next expected frame of dut d.
  task automatic commit(input int d);
    int len;
    len = frame_buf.size() * 10 * cpb_of(d);
    for (int k = 0; k < frame_buf.size(); k++) begin
      case (d)
        0: q0.push_back(frame_buf[k]);
        1: q1.push_back(frame_buf[k]);
        default: q2.push_back(frame_buf[k]);
      endcase
    end
    case (d)
      0: l0.push_back(len);
      1: l1.push_back(len);
      default: l2.push_back(len);
    endcase
    exp_frames[d]++;
  endtask

  // Hand-written frame: C0=16'h1234 and every other word zero.
  task automatic frame_single();
    frame_buf.delete();
    frame_buf.push_back(8'hA5);
    frame_buf.push_back(8'h34);
    frame_buf.push_back(8'h12);
    for (int k = 0; k < 30; k++) frame_buf.push_back(8'h00);
    frame_buf.push_back(8'h26);
  endtask

  // Hand-written frame: every word 16'hFFFF.
  task automatic frame_ones();
    frame_buf.delete();
    frame_buf.push_back(8'hA5);
    for (int k = 0; k < 32; k++) frame_buf.push_back(8'hFF);
    frame_buf.push_back(8'h00);
  endtask

  // Reference frame built from word values: words low byte first, XOR tail.
  task automatic frame_model(input logic [255:0] c);
    logic [7:0] cs;
    logic [15:0] w;
    cs = 8'h00;
    frame_buf.delete();
    frame_buf.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      w = c[16*i +: 16];
      frame_buf.push_back(w[7:0]);
      frame_buf.push_back(w[15:8]);
      cs = cs ^ w[7:0] ^ w[15:8];
    end
    frame_buf.push_back(cs);
  endtask

  // done is high at the second posedge; returns just after that edge.
  task automatic pulse_done(input int d);
    @(posedge clk); #1 done_w[d] = 1'b1;
    @(posedge clk); #1 done_w[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_w[d] && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d_frame_terminates", d), (n < 6000) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Monitors, one pair per instance
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    localparam int CPB = (gi == 0) ? 4 : ((gi == 1) ? 2 : 7);

    // UART receiver. All 10*CPB samples of a byte are checked, so a wrong
    // bit width or a glitch shows up as a shape error.
    initial begin : rx
      logic [7:0] b;
      logic [7:0] e;
      bit         ok;
      bit         abort;
      int         bad;
      int         bp;
      forever begin
        @(negedge clk);
        if (!reset && tx_w[gi] == 1'b0) begin
          abort = 1'b0;
          bad   = 0;
          b     = 8'h00;
          for (int s = 0; s < 10*CPB; s++) begin
            if (s > 0) @(negedge clk);
            if (reset) begin
              abort = 1'b1;
              break;
            end
            bp = s / CPB;
            if (bp == 0) begin
              if (tx_w[gi] !== 1'b0) bad++;
            end else if (bp == 9) begin
              if (tx_w[gi] !== 1'b1) bad++;
            end else if (s % CPB == 0) begin
              b[bp-1] = tx_w[gi];
            end else if (tx_w[gi] !== b[bp-1]) begin
              bad++;
            end
          end
          if (!abort) begin
            check($sformatf("dut%0d_bit_shape", gi), bad, 0);
            exp_pop(gi, e, ok);
            check($sformatf("dut%0d_byte_expected", gi), ok ? 1 : 0, 1);
            if (ok) check($sformatf("dut%0d_byte", gi), b, e);
          end
        end
      end
    end

    // busy length and frame_done alignment.
    initial begin : bm
      int cnt;
      int el;
      bit ok;
      bit prev_fd;
      cnt     = 0;
      prev_fd = 1'b0;
      forever begin
        @(negedge clk);
        if (fd_w[gi] === 1'b1) begin
          seen_frames[gi]++;
          check($sformatf("dut%0d_frame_done_width", gi), prev_fd ? 1 : 0, 0);
        end
        if (reset) begin
          cnt = 0;
        end else if (busy_w[gi]) begin
          cnt++;
        end else if (cnt > 0) begin
          check($sformatf("dut%0d_frame_done_at_busy_fall", gi), fd_w[gi], 1);
          len_pop(gi, el, ok);
          check($sformatf("dut%0d_len_expected", gi), ok ? 1 : 0, 1);
          if (ok) check($sformatf("dut%0d_busy_len", gi), cnt, el);
          $display("[TB] dut%0d frame ended after %0d busy cycles", gi, cnt);
          cnt = 0;
        end
        prev_fd = fd_w[gi];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin : stim
    logic [255:0] d1;
    logic [255:0] d2;
    logic [255:0] ord;

    for (int i = 0; i < 16; i++) begin
      d1[16*i +: 16]  = 16'(i * 16'h1111 + 16'h0F01);
      ord[16*i +: 16] = {8'(i), 8'(i + 8'h80)};
    end
    d2 = ~d1;

    reset  = 1'b1;
    done_w = 3'b000;
    c_flat = '0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_tx", tx_w, 3'b111);
    check("reset_busy", busy_w, 3'b000);
    check("reset_frame_done", fd_w, 3'b000);

    // Single word.
    $display("[TB] single word frame");
    c_flat = '0;
    c_flat[15:0] = 16'h1234;
    frame_single();
    commit(0);
    pulse_done(0);
    @(negedge clk);
    check("start_tx_low", tx_w[0], 0);
    check("start_busy_high", busy_w[0], 1);
    wait_idle(0);

    // All ones.
    $display("[TB] all ones frame");
    c_flat = '1;
    frame_ones();
    commit(0);
    pulse_done(0);
    wait_idle(0);

    // Byte ordering.
    $display("[TB] ordering frame");
    c_flat = ord;
    frame_model(ord);
    commit(0);
    pulse_done(0);
    wait_idle(0);

    // done re-pulsed mid-frame with new data: ignored.
    $display("[TB] busy lockout mid-frame");
    c_flat = d1;
    frame_model(d1);
    commit(0);
    pulse_done(0);
    repeat (98) @(posedge clk);
    c_flat = d2;
    pulse_done(0);
    wait_idle(0);
    repeat (60) @(posedge clk);

    // done held across the frame_done edge: ignored there, taken next edge.
    $display("[TB] back-to-back frames");
    c_flat = d1;
    frame_model(d1);
    commit(0);
    pulse_done(0);
    repeat (1359) @(posedge clk);
    #1 done_w[0] = 1'b1;
    c_flat = d2;
    frame_model(d2);
    commit(0);
    @(posedge clk);
    @(negedge clk);
    check("fd_edge_busy_low", busy_w[0], 0);
    check("fd_edge_pulse", fd_w[0], 1);
    @(posedge clk);
    #1 done_w[0] = 1'b0;
    @(negedge clk);
    check("restart_busy", busy_w[0], 1);
    check("restart_tx_start", tx_w[0], 0);
    wait_idle(0);

    // Reset during byte 5's data bits.
    $display("[TB] reset mid-frame");
    c_flat = d2;
    frame_model(d2);
    commit(0);
    pulse_done(0);
    repeat (210) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mid_tx", tx_w[0], 1);
    check("reset_mid_busy", busy_w[0], 0);
    check("reset_mid_frame_done", fd_w[0], 0);
    q0.delete();
    l0.delete();
    exp_frames[0]--;
    repeat (20) @(posedge clk);
    c_flat = ord;
    frame_model(ord);
    commit(0);
    pulse_done(0);
    wait_idle(0);

    // Baud sweep on the 2- and 7-clock instances.
    $display("[TB] baud sweep");
    c_flat = '0;
    c_flat[15:0] = 16'h1234;
    frame_single();
    commit(1);
    commit(2);
    @(posedge clk); #1 done_w = 3'b110;
    @(posedge clk); #1 done_w = 3'b000;
    wait_idle(1);
    wait_idle(2);
    repeat (20) @(posedge clk);

    check("dut0_bytes_left", q0.size(), 0);
    check("dut1_bytes_left", q1.size(), 0);
    check("dut2_bytes_left", q2.size(), 0);
    check("dut0_lens_left", l0.size(), 0);
    check("dut1_lens_left", l1.size(), 0);
    check("dut2_lens_left", l2.size(), 0);
    for (int d = 0; d < 3; d++)
      check($sformatf("dut%0d_frame_count", d), seen_frames[d], exp_frames[d]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
